multicycle_add_sub: RTL and testbench

// - Multicycle signed accumulator: one shared 8-bit adder/subtractor, sequenced by an internal control FSM, evaluates a 4-operand expression.
// - mode=0: R = A + B + C - D ; mode=1: R = A - B + C + D.
// - Standalone arithmetic block. The controller (FSM) and datapath (operand regs, accumulator, add/sub unit) live in one wrapper.

---
 rtl/multicycle_add_sub_pkg.sv | 48 ++++
 rtl/addsub_unit.sv | 17 +
 rtl/multicycle_add_sub.sv | 112 +++++++++++
 tb/tb_multicycle_add_sub.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/multicycle_add_sub_pkg.sv
// Shared definitions for the multicycle add/sub accumulator.
//   W          : operand/result width (two's-complement signed)
//   state_e    : controller state encoding
//   OP_ADD/SUB : adder operation encoding
//   step_of    : one-hot phase indicator for a given state
//   op_of      : adder operation applied in a given state
package multicycle_add_sub_pkg;

  localparam int unsigned W = 8;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StS0   = 3'd1,
    StS1   = 3'd2,
    StS2   = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // {s2,s1,s0}; all zero outside the arithmetic phases.
  function automatic logic [2:0] step_of(state_e s);
    logic [2:0] v;
    v = 3'b000;
    case (s)
      StS0:    v = 3'b001;
      StS1:    v = 3'b010;
      StS2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // mode=0: A + B + C - D ; mode=1: A - B + C + D.
  function automatic logic op_of(state_e s, logic mode);
    logic v;
    v = OP_ADD;
    case (s)
      StS0:    v = mode ? OP_SUB : OP_ADD;
      StS1:    v = OP_ADD;
      StS2:    v = mode ? OP_ADD : OP_SUB;
      default: v = OP_ADD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// Combinational W-bit adder/subtractor, wraps modulo 2^W.
//   i_x, i_y : operands
//   i_sub    : 0 = add, 1 = subtract
//   o_sum    : i_sub ? i_x - i_y : i_x + i_y
module addsub_unit #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_sub,
  output logic [W-1:0] o_sum
);

  // Subtract as x + ~y + 1 so one adder serves both operations.
  assign o_sum = i_x + (i_y ^ {W{i_sub}}) + {{(W-1){1'b0}}, i_sub};

endmodule

// File: rtl/multicycle_add_sub.sv
// Multicycle signed accumulator evaluating a 4-operand expression on one shared adder.
//   i_clk, i_rst_n   : rising-edge clock, asynchronous active-low reset
//   i_start          : request, sampled only in idle
//   i_mode           : 0 -> A+B+C-D, 1 -> A-B+C+D (sampled with i_start)
//   i_a..i_d         : signed operands (sampled with i_start)
//   o_result         : running accumulator / final result
//   o_done           : high while the result is final
//   o_step           : one-hot active phase {s2,s1,s0}
//   o_add_or_sub     : adder operation of the active phase (0 add, 1 sub)
module multicycle_add_sub
  import multicycle_add_sub_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_mode,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_result,
  output logic         o_done,
  output logic [2:0]   o_step,
  output logic         o_add_or_sub
);

  state_e       r_state, w_state_d;
  logic [W-1:0] r_a, r_b, r_c, r_d, r_acc;
  logic         r_mode, w_mode_d;
  logic         r_done;
  logic [2:0]   r_step;
  logic         r_aos;
  logic         w_load;
  logic [W-1:0] w_x, w_y, w_sum;
  logic         w_sub;

  assign w_load   = (r_state == StIdle) && i_start;
  // Mode as it will be after this edge, so the registered op output lines up with the state.
  assign w_mode_d = w_load ? i_mode : r_mode;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_d = StS0;
      StS0:    w_state_d = StS1;
      StS1:    w_state_d = StS2;
      StS2:    w_state_d = StDone;
      StDone:  if (!i_start) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_x = r_acc;
    w_y = r_d;
    case (r_state)
      StS0: begin
        w_x = r_a;
        w_y = r_b;
      end
      StS1:    w_y = r_c;
      default: w_y = r_d;
    endcase
  end

  assign w_sub = op_of(r_state, r_mode);

  addsub_unit #(
    .W (W)
  ) u_addsub (
    .i_x   (w_x),
    .i_y   (w_y),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_mode  <= 1'b0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_step  <= 3'b000;
      r_aos   <= OP_ADD;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_a <= i_a;
        r_b <= i_b;
        r_c <= i_c;
        r_d <= i_d;
      end
      r_mode <= w_mode_d;
      if (r_state == StS0 || r_state == StS1 || r_state == StS2) begin
        r_acc <= w_sum;
      end
      r_done <= (w_state_d == StDone);
      r_step <= step_of(w_state_d);
      r_aos  <= op_of(w_state_d, w_mode_d);
    end
  end

  assign o_result     = r_acc;
  assign o_done       = r_done;
  assign o_step       = r_step;
  assign o_add_or_sub = r_aos;

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Scoreboard bench for multicycle_add_sub: directed vectors push their expected final
// result into a queue; a monitor pops and compares each time o_done rises.
module tb_multicycle_add_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] a, b, c, d;
  logic [7:0] result;
  logic       done;
  logic [2:0] step;
  logic       aos;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic       prev_done = 1'b0;

  always #5 clk = ~clk;

  multicycle_add_sub dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_mode       (mode),
    .i_a          (a),
    .i_b          (b),
    .i_c          (c),
    .i_d          (d),
    .o_result     (result),
    .o_done       (done),
    .o_step       (step),
    .o_add_or_sub (aos)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: outputs sampled on the falling edge, well away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", {7'd0, done}, 8'd0);
        else chk("result", result, exp_q.pop_front());
      end
      prev_done = done;
    end
  end

  // Called just after a falling edge with the DUT idle; returns at the falling edge in DONE.
  task automatic run_op(input string name, input logic m, input int va, input int vb,
                        input int vc, input int vd, input int p0, input int p1,
                        input int fin, input bit hold);
    start = 1'b1;
    mode  = m;
    a     = 8'(va);
    b     = 8'(vb);
    c     = 8'(vc);
    d     = 8'(vd);
    exp_q.push_back(8'(fin));
    @(negedge clk);                                   // S0
    if (!hold) start = 1'b0;
    mode = 1'bx;
    a = 'x; b = 'x; c = 'x; d = 'x;
    chk({name, "_s0_step"}, {5'd0, step}, 8'h01);
    chk({name, "_s0_done"}, {7'd0, done}, 8'd0);
    @(negedge clk);                                   // S1
    chk({name, "_s1_result"}, result, 8'(p0));
    chk({name, "_s1_step"}, {5'd0, step}, 8'h02);
    chk({name, "_s1_op"}, {7'd0, aos}, 8'd0);
    @(negedge clk);                                   // S2
    chk({name, "_s2_result"}, result, 8'(p1));
    chk({name, "_s2_step"}, {5'd0, step}, 8'h04);
    chk({name, "_s2_op"}, {7'd0, aos}, m ? 8'd0 : 8'd1);
    @(negedge clk);                                   // DONE, four edges after start
    chk({name, "_done"}, {7'd0, done}, 8'd1);
    chk({name, "_done_step"}, {5'd0, step}, 8'h00);
    if (!hold) begin
      @(negedge clk);                                 // back in IDLE
      chk({name, "_done_drop"}, {7'd0, done}, 8'd0);
      chk({name, "_final_hold"}, result, 8'(fin));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    #3;
    chk("rst_result", result, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_step", {5'd0, step}, 8'd0);
    chk("rst_op", {7'd0, aos}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", 1'b0, 1, 2, -1, 2, 3, 2, 0, 1'b0);
    run_op("t2", 1'b1, -2, 1, 1, 4, -3, -2, 2, 1'b0);
    run_op("t3", 1'b0, 1, -1, -1, 2, 0, -1, -3, 1'b0);
    run_op("t4", 1'b1, -2, 2, -1, 2, -4, -5, -3, 1'b0);
    repeat (2) @(negedge clk);                        // mode/operands still X
    chk("t4_x_result", result, 8'hFD);

    run_op("t5", 1'b0, 127, 1, 0, 0, -128, -128, -128, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_done", {7'd0, done}, 8'd1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("t5_drop_done", {7'd0, done}, 8'd0);
    chk("t5_drop_result", result, 8'h80);

    // T6: abort in S1; this operation never completes, so nothing is queued.
    start = 1'b1;
    mode  = 1'b0;
    a = 8'd1; b = 8'd2; c = 8'hFF; d = 8'd2;
    @(negedge clk);                                   // S0
    start = 1'b0;
    @(negedge clk);                                   // S1
    chk("t6_pre_result", result, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_abort_result", result, 8'd0);
    chk("t6_abort_done", {7'd0, done}, 8'd0);
    chk("t6_abort_step", {5'd0, step}, 8'd0);
    chk("t6_abort_op", {7'd0, aos}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("t6_rerun", 1'b0, 1, 2, -1, 2, 3, 2, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
